// File: rtl/blink4_pkg.sv
// Shared constants and helpers for the blink4 LED blinker.
package blink4_pkg;

   localparam int NUM_LEDS     = 4;
   localparam int DEF_TICK_DIV = 5;
   localparam int DEF_HALF1    = 1;
   localparam int DEF_HALF2    = 2;
   localparam int DEF_HALF3    = 4;
   localparam int DEF_HALF4    = 8;

   // Width of a counter that must hold 0..n-1; a 1-bit counter is the minimum.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/blink4_toggle.sv
// Half-period counter plus toggle register for one LED channel.
// wrap is high on the tick where the half-period completes.
module blink4_toggle
   import blink4_pkg::*;
#(
   parameter int HALF = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   output logic led,
   output logic wrap
);

   localparam int           W    = cnt_width(HALF);
   localparam logic [W-1:0] LAST = W'(HALF - 1);

   logic [W-1:0] cnt;

   assign wrap = tick && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         led <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         led <= ~led;
      end else if (tick) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/blink4.sv
// Four-LED blinker: shared prescaler tick, per-LED half-period toggles.
// Define BLINK4_CHASE_EN to turn the LEDs into a one-hot running light stepped every HALF1 ticks.
module blink4
   import blink4_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int HALF1    = DEF_HALF1,
   parameter int HALF2    = DEF_HALF2,
   parameter int HALF3    = DEF_HALF3,
   parameter int HALF4    = DEF_HALF4
) (
   input  logic clk,
   input  logic rst,
   output logic led1,
   output logic led2,
   output logic led3,
   output logic led4
);

   localparam int            PW    = cnt_width(TICK_DIV);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;
   logic          tick;

   assign tick = (pcnt == PLAST);

   always_ff @(posedge clk) begin
      if (rst || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

`ifdef BLINK4_CHASE_EN

   localparam int unused_half_sum = HALF2 + HALF3 + HALF4;

   logic                shift;
   logic                unused_led;
   logic [NUM_LEDS-1:0] chase;

   blink4_toggle #(.HALF(HALF1)) u_step (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .led  (unused_led),
      .wrap (shift)
   );

   // Rotate toward higher LED numbers; led4 wraps back to led1.
   always_ff @(posedge clk) begin
      if (rst) begin
         chase <= NUM_LEDS'(1);
      end else if (shift) begin
         chase <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
      end
   end

   assign {led4, led3, led2, led1} = chase;

`else

   logic [NUM_LEDS-1:0] led_v;
   logic [NUM_LEDS-1:0] unused_wrap;

   blink4_toggle #(.HALF(HALF1)) u_t1 (
      .clk (clk), .rst (rst), .tick (tick), .led (led_v[0]), .wrap (unused_wrap[0])
   );
   blink4_toggle #(.HALF(HALF2)) u_t2 (
      .clk (clk), .rst (rst), .tick (tick), .led (led_v[1]), .wrap (unused_wrap[1])
   );
   blink4_toggle #(.HALF(HALF3)) u_t3 (
      .clk (clk), .rst (rst), .tick (tick), .led (led_v[2]), .wrap (unused_wrap[2])
   );
   blink4_toggle #(.HALF(HALF4)) u_t4 (
      .clk (clk), .rst (rst), .tick (tick), .led (led_v[3]), .wrap (unused_wrap[3])
   );

   assign {led4, led3, led2, led1} = led_v;

`endif

endmodule

// File: tb/tb_blink4.sv
// Randomised-reset bench for blink4: three parameter sets checked every cycle against an edge-count model.
module tb_blink4;

   logic clk = 1'b0;
   logic rst;

   logic [3:0] led_def, led_c1, led_c2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   blink4 u_def (
      .clk (clk), .rst (rst),
      .led1 (led_def[0]), .led2 (led_def[1]), .led3 (led_def[2]), .led4 (led_def[3])
   );

   blink4 #(.TICK_DIV(1), .HALF1(1), .HALF2(1), .HALF3(1), .HALF4(1)) u_c1 (
      .clk (clk), .rst (rst),
      .led1 (led_c1[0]), .led2 (led_c1[1]), .led3 (led_c1[2]), .led4 (led_c1[3])
   );

   blink4 #(.TICK_DIV(3), .HALF3(5)) u_c2 (
      .clk (clk), .rst (rst),
      .led1 (led_c2[0]), .led2 (led_c2[1]), .led3 (led_c2[2]), .led4 (led_c2[3])
   );

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at time %0t", tag, got, exp, $time);
      end
   endtask

   // k = rising edges since the last edge that sampled rst=1.
   function automatic logic [3:0] model(input int k, input int div,
                                        input int h1, input int h2, input int h3, input int h4);
      logic [3:0] r;
`ifdef BLINK4_CHASE_EN
      int p;
      p = (k / (div * h1)) % 4;
      r = 4'b0001 << p;
`else
      r[0] = ((k / (div * h1)) % 2) == 1;
      r[1] = ((k / (div * h2)) % 2) == 1;
      r[2] = ((k / (div * h3)) % 2) == 1;
      r[3] = ((k / (div * h4)) % 2) == 1;
`endif
      return r;
   endfunction

   initial begin
      int k;
      int rst_left;
      rst = 1'b1;
      k = 0;
      rst_left = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
`ifdef BLINK4_CHASE_EN
      chk("reset_def", led_def, 4'b0001);
`else
      chk("reset_def", led_def, 4'b0000);
`endif
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(posedge clk);
         if (rst) k = 0;
         else     k++;
         @(negedge clk);
         chk("def",       led_def, model(k, 5, 1, 2, 4, 8));
         chk("all_one",   led_c1,  model(k, 1, 1, 1, 1, 1));
         chk("div3_half5", led_c2, model(k, 3, 1, 2, 5, 8));
         if (rst_left > 0) begin
            rst_left--;
         end else if (cyc == 37) begin
            rst_left = 1;
         end else if ($urandom_range(0, 999) == 0) begin
            rst_left = $urandom_range(1, 3);
         end
         rst = (rst_left > 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
